multicycle_ctrl: RTL

Multi-cycle main controller for the MIPS datapath. It replaces the single-cycle combinational decoder with a state machine that sequences each instruction over 3–5 clocks. The datapath shares one ALU and one memory port, with IR, A/B and ALUOut holding registers. The block sits between the instruction register fields (OpCode/func) and every datapath write-enable and mux select. It also reports instruction completion and illegal opcodes.

---
 rtl/multicycle_ctrl.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences each instruction over 2-5 states and
// drives every datapath enable/select combinationally from the registered state.
//
// state   | meaning
// FETCH   | IR <- mem[PC], PC <- PC+4
// DECODE  | branch target -> ALUOut, dispatch on OpCode/func
// EXE_R   | R-type ALU op on A,B
// EXE_I   | I-type ALU op on A,Ext
// MEM_ADR | effective address A+SignExt
// MEM_RD  | data memory read
// MEM_WB  | MDR -> rt
// MEM_WR  | data memory write
// ALU_WB  | ALUOut -> rd/rt
// BRANCH  | beq compare, PC <- ALUOut on zero
// JUMP    | j/jal/jr PC update (jal links $31)
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       overflow,
  input  logic       AddressError,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUop,
  output logic [1:0] Extop,
  output logic [1:0] RegDst,
  output logic [1:0] WBSel,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WB  = 4'd6,
    MEM_WR  = 4'd7,
    ALU_WB  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10
  } state_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_PASS = 3'b100;

  state_t cur_q;
  state_t next_state;
  // Suppress flag: overflow from EXE_I or address error from MEM_RD
  logic   flag_q;

  logic is_r, op_addu, op_subu, op_slt, op_jr;
  logic op_addi, op_ori, op_lui, op_lw, op_sw, op_beq, op_j, op_jal;
  logic r_alu, i_alu;

  assign is_r    = (OpCode == 6'b000000);
  assign op_addu = is_r && (func == 6'b100001);
  assign op_subu = is_r && (func == 6'b100011);
  assign op_slt  = is_r && (func == 6'b101010);
  assign op_jr   = is_r && (func == 6'b001000);
  assign op_addi = (OpCode == 6'b001000);
  assign op_ori  = (OpCode == 6'b001101);
  assign op_lui  = (OpCode == 6'b001111);
  assign op_lw   = (OpCode == 6'b100011);
  assign op_sw   = (OpCode == 6'b101011);
  assign op_beq  = (OpCode == 6'b000100);
  assign op_j    = (OpCode == 6'b000010);
  assign op_jal  = (OpCode == 6'b000011);
  assign r_alu   = op_addu || op_subu || op_slt;
  assign i_alu   = op_addi || op_ori || op_lui;

  assign state = cur_q;

  always_comb begin
    next_state = FETCH;
    case (cur_q)
      FETCH:   next_state = DECODE;
      DECODE: begin
        if (r_alu)                       next_state = EXE_R;
        else if (i_alu)                  next_state = EXE_I;
        else if (op_lw || op_sw)         next_state = MEM_ADR;
        else if (op_beq)                 next_state = BRANCH;
        else if (op_j || op_jal || op_jr) next_state = JUMP;
        else                             next_state = FETCH;
      end
      EXE_R:   next_state = ALU_WB;
      EXE_I:   next_state = ALU_WB;
      MEM_ADR: next_state = op_lw ? MEM_RD : (op_sw ? MEM_WR : FETCH);
      MEM_RD:  next_state = MEM_WB;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q  <= FETCH;
      flag_q <= 1'b0;
    end else begin
      cur_q <= next_state;
      case (cur_q)
        FETCH:   flag_q <= 1'b0;
        EXE_I:   flag_q <= overflow;
        MEM_RD:  flag_q <= AddressError;
        default: flag_q <= flag_q;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUop      = ALU_ADD;
    Extop      = 2'b00;
    RegDst     = 2'b00;
    WBSel      = 2'b00;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (cur_q)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        Extop   = 2'b01;
        if (!(r_alu || i_alu || op_lw || op_sw || op_beq || op_j || op_jal || op_jr)) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      EXE_R: begin
        ALUSrcA = 1'b1;
        if (op_subu)     ALUop = ALU_SUB;
        else if (op_slt) ALUop = ALU_SLT;
        else             ALUop = ALU_ADD;
      end
      EXE_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (op_ori) begin
          Extop = 2'b00;
          ALUop = ALU_OR;
        end else if (op_lui) begin
          Extop = 2'b10;
          ALUop = ALU_PASS;
        end else begin
          Extop = 2'b01;
          ALUop = ALU_ADD;
        end
      end
      MEM_ADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Extop   = 2'b01;
      end
      MEM_WB: begin
        RegWrite   = !flag_q;
        WBSel      = 2'b01;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        MemWrite   = !AddressError;
        instr_done = 1'b1;
      end
      ALU_WB: begin
        RegWrite   = !(op_addi && flag_q);
        RegDst     = is_r ? 2'b01 : 2'b00;
        instr_done = 1'b1;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUop      = ALU_SUB;
        PCSrc      = 2'b01;
        PCWrite    = zero;
        instr_done = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        PCSrc      = op_jr ? 2'b11 : 2'b10;
        if (op_jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          WBSel    = 2'b10;
        end
      end
      default: ;
    endcase
    // A reset edge must never commit a write or report a completion
    if (reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
